// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: XLEN, fetch FSM states, PC increment.
// No logic; imported by pc_reg and pc_fetch_unit.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    TRAP
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// XLEN-bit program-counter register with load enable and reset value.
// Latency: d appears on q one cycle after load; no backpressure.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + single-outstanding fetch sequencer; best case 3 cycles/instr.
// Backpressure: stalls in REQ on imem_req_ready, in HOLD on instr_ready. Option: FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic            pc_load;
  logic [XLEN-1:0] pc_load_val;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned targets still land in pc so the faulting address is visible.
  assign pc_load_val = pc_next;
`else
  assign pc_load_val = pc_next & ALIGN_MASK;
`endif

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (pc_load),
    .d    (pc_load_val),
    .q    (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_req_ready) state_d = WAIT;
      WAIT: if (imem_rsp_valid) state_d = HOLD;
      HOLD: begin
        if (instr_ready) begin
          pc_load = 1'b1;
          state_d = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_next[1:0] != 2'b00) state_d = TRAP;
`endif
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Responses outside WAIT are stale (e.g. from before a reset) and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (state_q == WAIT && imem_rsp_valid) begin
      instr    <= imem_rsp_data;
      instr_pc <= pc;
    end
  end

  assign pc_plus4       = pc + PC_INC;
  assign imem_addr      = pc;
  assign imem_req_valid = (state_q == REQ);
  assign instr_valid    = (state_q == HOLD);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign = (state_q == TRAP);
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, reset-in-WAIT sequence,
// and randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_next = '0;
  logic [31:0] pc, pc_plus4, imem_addr, instr, instr_pc;
  logic        imem_req_valid, instr_valid, fetch_misalign;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_ready = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_misalign(fetch_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic e_rv, input logic [31:0] e_addr,
                         input logic e_iv, input logic [31:0] e_instr,
                         input logic [31:0] e_ipc, input logic e_mis);
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(e_rv));
    chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk({tag, ".pc"}, pc, e_addr);
    chk({tag, ".pc_plus4"}, pc_plus4, e_addr + 32'd4);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_iv));
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".instr_pc"}, instr_pc, e_ipc);
    chk({tag, ".misalign"}, 32'(fetch_misalign), 32'(e_mis));
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic [31:0] pn);
    imem_req_ready = rr;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    instr_ready    = ir;
    pc_next        = pn;
  endtask

  // Leaves the DUT freshly out of reset (IDLE) at a falling edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rr, rv, ir;
    logic [31:0] rd, pn;
    logic        e_rv, e_iv, e_mis;
    logic [31:0] e_addr, e_instr, e_ipc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rr, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic [31:0] pn,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_mis);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.pn = pn;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  // Transaction-level reference: flags for "fetch issued" and "instruction held".
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_started, m_issued, m_have, m_trap;

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_ipc = '0;
    m_started = 0; m_issued = 0; m_have = 0; m_trap = 0;
  endtask

  task automatic model_step();
    if (!m_started) begin
      m_started = 1;
    end else if (m_trap) begin
      // only reset leaves
    end else if (m_have) begin
      if (instr_ready) begin
        m_pc   = TRAP_EN ? pc_next : (pc_next & 32'hFFFF_FFFC);
        m_have = 0;
        if (TRAP_EN && pc_next[1:0] != 2'b00) m_trap = 1;
      end
    end else if (m_issued) begin
      if (imem_rsp_valid) begin
        m_instr = imem_rsp_data; m_ipc = m_pc; m_have = 1; m_issued = 0;
      end
    end else if (imem_req_ready) begin
      m_issued = 1;
    end
  endtask

  initial begin
    logic [31:0] a24, a27;
    // ---- reset values
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed vector table (each row: expect at start of cycle, then drive)
    add(1,0,'0,0,'0,            0, 32'h1000, 0, 32'h0, 32'h0, 0);           // IDLE
    add(1,0,'0,0,'0,            1, 32'h1000, 0, 32'h0, 32'h0, 0);           // REQ
    add(0,1,32'hDEADBEEF,0,'0,  0, 32'h1000, 0, 32'h0, 32'h0, 0);           // WAIT
    add(0,0,'0,1,32'h1004,      0, 32'h1000, 1, 32'hDEADBEEF, 32'h1000, 0); // HOLD
    for (int k = 0; k < 5; k++)                                             // REQ stalled
      add(0,1,32'h1111_1111,0,'0, 1, 32'h1004, 0, 32'hDEADBEEF, 32'h1000, 0);
    add(1,0,'0,0,'0,            1, 32'h1004, 0, 32'hDEADBEEF, 32'h1000, 0);
    add(0,0,'0,0,'0,            0, 32'h1004, 0, 32'hDEADBEEF, 32'h1000, 0);
    add(0,1,32'hCAFE0001,0,'0,  0, 32'h1004, 0, 32'hDEADBEEF, 32'h1000, 0);
    for (int k = 0; k < 4; k++)                                             // HOLD stalled
      add(0,0,'0,0,32'h2000 + 32'(k) * 32'h100, 0, 32'h1004, 1, 32'hCAFE0001, 32'h1004, 0);
    add(0,0,'0,1,32'hFFFF_FFFC, 0, 32'h1004, 1, 32'hCAFE0001, 32'h1004, 0);
    add(1,0,'0,0,'0,            1, 32'hFFFF_FFFC, 0, 32'hCAFE0001, 32'h1004, 0);
    add(0,1,32'h13,0,'0,        0, 32'hFFFF_FFFC, 0, 32'hCAFE0001, 32'h1004, 0);
    add(0,0,'0,1,32'h0,         0, 32'hFFFF_FFFC, 1, 32'h13, 32'hFFFF_FFFC, 0);
    add(1,0,'0,0,'0,            1, 32'h0, 0, 32'h13, 32'hFFFF_FFFC, 0);
    add(0,1,32'h00A00093,0,'0,  0, 32'h0, 0, 32'h13, 32'hFFFF_FFFC, 0);
    add(0,0,'0,1,32'h2002,      0, 32'h0, 1, 32'h00A00093, 32'h0, 0);
    a24 = TRAP_EN ? 32'h2002 : 32'h2000;
    add(1,0,'0,0,'0,            !TRAP_EN, a24, 0, 32'h00A00093, 32'h0, TRAP_EN);
    add(0,1,32'h77,0,'0,        0, a24, 0, 32'h00A00093, 32'h0, TRAP_EN);
    add(0,0,'0,1,32'h3000,      0, a24, !TRAP_EN,
        TRAP_EN ? 32'h00A00093 : 32'h77, TRAP_EN ? 32'h0 : 32'h2000, TRAP_EN);
    a27 = TRAP_EN ? 32'h2002 : 32'h3000;
    add(1,0,'0,0,'0,            !TRAP_EN, a27, 0,
        TRAP_EN ? 32'h00A00093 : 32'h77, TRAP_EN ? 32'h0 : 32'h2000, TRAP_EN);

    foreach (tbl[i]) begin
      chk_all($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
              tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_mis);
      drive(tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].pn);
      @(posedge clk);
      @(negedge clk);
    end

    // ---- reset asserted in WAIT, then a stale response after release
    do_reset();
    drive(1,0,'0,0,'0);
    @(posedge clk); @(negedge clk);          // REQ
    @(posedge clk); @(negedge clk);          // WAIT
    drive(0,0,'0,0,'0);
    rst_n = 1'b0;
    #1;
    chk_all("rst_wait", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,1,32'h5555_AAAA,1,32'h4000);     // stale pulse lands in IDLE
    @(posedge clk); @(negedge clk);
    chk_all("late_rsp_req", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(0,1,32'h6666_BBBB,1,32'h4000);     // and in REQ
    @(posedge clk); @(negedge clk);
    chk_all("late_rsp_req2", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);

    // ---- randomized traffic vs. reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      chk_all("rand", m_started && !m_issued && !m_have && !m_trap, m_pc, m_have,
              m_instr, m_ipc, m_trap);
      if ((m_trap && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
        model_reset();
      end else begin
        drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom,
              $urandom_range(0, 4) < 3,
              ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        @(posedge clk);
        model_step();
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
